// File: rtl/kbd_pkg.sv
// Shared types and constants for the matrix-keypad scanner.
package kbd_pkg;

  // Scanner FSM states.
  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE_P,
    HELD
  } kbd_state_e;

  localparam int unsigned KEY_CODE_W = 4;

  // Column count of the default keypad; also the row stride of key_code.
  localparam int unsigned KBD_COLS = 2;

  // key_code = row * cols + col, truncated to the key_code width.
  function automatic logic [KEY_CODE_W-1:0] key_code_f(input int unsigned row,
                                                       input int unsigned col,
                                                       input int unsigned cols);
    return KEY_CODE_W'(row * cols + col);
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Free-running slot counter; strobes on the last cycle of every row slot.
module scan_tick #(
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic clk_s,
  input  logic rst,
  output logic sample_o
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Strobe on the final count and wrap back to zero.
  always_comb begin
    sample_o = (cnt_q == LastCnt);
    cnt_d    = sample_o ? '0 : cnt_q + 1'b1;
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk_s) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix-keypad scanner: row drive, column sampling, press/release debounce.
module keypad_scanner import kbd_pkg::*; #(
  parameter int unsigned ROWS     = 5,
  parameter int unsigned COLS     = KBD_COLS,
  parameter int unsigned SCAN_DIV = 16,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                  clk_s,
  input  logic                  rst,
  input  logic [COLS-1:0]       K_COL,
  output logic [ROWS-1:0]       K_ROW,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  key_valid,
  output logic                  key_held,
  output logic                  key_release
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE + 1);
  localparam logic [CntW-1:0] DebCnt  = CntW'(DEBOUNCE);
  localparam logic [RowW-1:0] LastRow = RowW'(ROWS - 1);

  kbd_state_e            state_q, state_d;
  logic [RowW-1:0]       row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [CntW-1:0]       match_cnt_q, match_cnt_d;
  logic [CntW-1:0]       rel_cnt_q, rel_cnt_d;
  logic [KEY_CODE_W-1:0] key_code_q, key_code_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_held_q, key_held_d;
  logic                  key_release_q, key_release_d;

  logic            sample;
  logic            low_any;
  logic [ColW-1:0] low_col;
  logic [RowW-1:0] row_next;
  logic            cand_low;
  logic            accept;

  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk_s    (clk_s),
    .rst      (rst),
    .sample_o (sample)
  );

  // Lowest-index closed column wins; higher ones are dropped.
  always_comb begin
    low_any = 1'b0;
    low_col = '0;
    for (int i = int'(COLS) - 1; i >= 0; i--) begin
      if (!K_COL[i]) begin
        low_any = 1'b1;
        low_col = ColW'(i);
      end
    end
    row_next = (row_q == LastRow) ? '0 : row_q + 1'b1;
    cand_low = !K_COL[col_q];
  end

  // Next-state: scanning, press debounce, release debounce; acts only at the sample point.
  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    match_cnt_d   = match_cnt_q;
    rel_cnt_d     = rel_cnt_q;
    key_code_d    = key_code_q;
    key_valid_d   = 1'b0;
    key_held_d    = key_held_q;
    key_release_d = 1'b0;
    accept        = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (sample) begin
          if (low_any) begin
            col_d       = low_col;
            match_cnt_d = CntW'(1);
            state_d     = DEBOUNCE_P;
            accept      = (match_cnt_d == DebCnt);
          end else begin
            row_d = row_next;
          end
        end
      end
      DEBOUNCE_P: begin
        if (sample) begin
          if (cand_low) begin
            match_cnt_d = match_cnt_q + 1'b1;
            accept      = (match_cnt_d == DebCnt);
          end else begin
            state_d = SCAN;
            row_d   = row_next;
          end
        end
      end
      HELD: begin
        if (sample) begin
          if (!cand_low) begin
            rel_cnt_d = rel_cnt_q + 1'b1;
            if (rel_cnt_d == DebCnt) begin
              key_release_d = 1'b1;
              key_held_d    = 1'b0;
              state_d       = SCAN;
              row_d         = row_next;
            end
          end else begin
            // A re-closure restarts the release count.
            rel_cnt_d = '0;
          end
        end
      end
      default: state_d = SCAN;
    endcase

    // Row is frozen while debouncing, so row_q is the candidate row.
    if (accept) begin
      key_code_d  = key_code_f(32'(row_q), 32'(col_d), COLS);
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
      rel_cnt_d   = '0;
      state_d     = HELD;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_s) begin
    if (rst) begin
      state_q       <= SCAN;
      row_q         <= '0;
      col_q         <= '0;
      match_cnt_q   <= '0;
      rel_cnt_q     <= '0;
      key_code_q    <= '0;
      key_valid_q   <= 1'b0;
      key_held_q    <= 1'b0;
      key_release_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      match_cnt_q   <= match_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      key_code_q    <= key_code_d;
      key_valid_q   <= key_valid_d;
      key_held_q    <= key_held_d;
      key_release_q <= key_release_d;
    end
  end

  assign K_ROW       = ~(ROWS'(1) << row_q);
  assign key_code    = key_code_q;
  assign key_valid   = key_valid_q;
  assign key_held    = key_held_q;
  assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, behavioural reference, directed scenarios.
module tb_keypad_scanner;

  localparam int ROWS = 5;
  localparam int COLS = 2;
  localparam int SDIV = 16;
  localparam int DEB  = 4;

  logic            clk_s;
  logic            rst;
  logic [COLS-1:0] K_COL;
  logic [ROWS-1:0] K_ROW;
  logic [3:0]      key_code;
  logic            key_valid;
  logic            key_held;
  logic            key_release;

  keypad_scanner #(
    .ROWS     (ROWS),
    .COLS     (COLS),
    .SCAN_DIV (SDIV),
    .DEBOUNCE (DEB)
  ) dut (
    .clk_s       (clk_s),
    .rst         (rst),
    .K_COL       (K_COL),
    .K_ROW       (K_ROW),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  // Keypad matrix: closed switch pulls its column low while its row is driven.
  bit key_m [ROWS][COLS];
  bit bounce;

  always_comb begin
    K_COL = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (key_m[r][c] && !K_ROW[r]) K_COL[c] = 1'b0;
      end
    end
    if (bounce && !K_ROW[1]) K_COL[0] = 1'b0;
  end

  int checks;
  int passes;
  int n;
  int valid_cnt;
  int rel_pulses;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s got %0h exp %0h", name, got, exp);
  endtask

  // Reference: slot position, row under scan, phase (idle/confirming/held) and run length.
  typedef struct {
    int slot;
    int row;
    int phase;
    int run;
    int col;
    int code;
    bit held;
    bit valid;
    bit rel;
    bit ok;
  } model_t;

  model_t m;

  function automatic model_t step_model(model_t s, logic [COLS-1:0] kc, logic r);
    model_t ns;
    int     lows;
    ns = s;
    if (r) begin
      ns.slot = 0; ns.row = 0; ns.phase = 0; ns.run = 0; ns.col = 0; ns.code = 0;
      ns.held = 0; ns.valid = 0; ns.rel = 0; ns.ok = 1;
      return ns;
    end
    ns.valid = 0;
    ns.rel   = 0;
    if (s.slot == SDIV - 1) begin
      lows = int'(~kc) & ((1 << COLS) - 1);
      case (s.phase)
        0: begin
          if (lows == 0) ns.row = (s.row + 1) % ROWS;
          else begin
            ns.col   = (lows & 1) ? 0 : 1;
            ns.run   = 1;
            ns.phase = 1;
          end
        end
        1: begin
          if (kc[s.col] == 1'b0) begin
            ns.run = s.run + 1;
            if (ns.run == DEB) begin
              ns.code  = s.row * COLS + s.col;
              ns.valid = 1;
              ns.held  = 1;
              ns.phase = 2;
              ns.run   = 0;
            end
          end else begin
            ns.phase = 0;
            ns.row   = (s.row + 1) % ROWS;
          end
        end
        default: begin
          if (kc[s.col] == 1'b1) begin
            ns.run = s.run + 1;
            if (ns.run == DEB) begin
              ns.rel   = 1;
              ns.held  = 0;
              ns.phase = 0;
              ns.run   = 0;
              ns.row   = (s.row + 1) % ROWS;
            end
          end else begin
            ns.run = 0;
          end
        end
      endcase
    end
    ns.slot = (s.slot + 1) % SDIV;
    return ns;
  endfunction

  initial m = '{default: 0};

  // Advance the reference on the same edge as the DUT.
  always @(posedge clk_s) m <= step_model(m, K_COL, rst);

  // Compare every cycle once the reference has seen a reset.
  always @(negedge clk_s) begin
    if (m.ok) begin
      chk("cyc_k_row", int'(K_ROW), 'h1F ^ (1 << m.row));
      chk("cyc_key_code", int'(key_code), m.code);
      chk("cyc_key_valid", int'(key_valid), int'(m.valid));
      chk("cyc_key_held", int'(key_held), int'(m.held));
      chk("cyc_key_release", int'(key_release), int'(m.rel));
      chk("cyc_excl", int'(key_valid & key_release), 0);
    end
    if (key_valid) valid_cnt++;
    if (key_release) rel_pulses++;
  end

  task automatic step();
    @(negedge clk_s);
    n++;
  endtask

  task automatic run_to(input int t);
    while (n < t) step();
  endtask

  task automatic clear_keys();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) key_m[r][c] = 0;
    bounce = 0;
  endtask

  // Two reset edges; n counts rising edges after release.
  task automatic do_reset();
    @(negedge clk_s);
    rst = 1'b1;
    @(negedge clk_s);
    @(negedge clk_s);
    rst        = 1'b0;
    n          = 0;
    valid_cnt  = 0;
    rel_pulses = 0;
  endtask

  task automatic find_valid(output int at);
    at = -1;
    for (int k = 0; k < 300; k++) begin
      step();
      if (key_valid) begin
        at = n;
        break;
      end
    end
  endtask

  task automatic find_release(output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      step();
      if (key_release) begin
        at = n;
        break;
      end
    end
  endtask

  initial begin
    int at;
    rst = 1'b0;
    clear_keys();

    // Idle sweep.
    do_reset();
    chk("rst_k_row", int'(K_ROW), 'h1E);
    chk("rst_key_code", int'(key_code), 0);
    chk("rst_key_held", int'(key_held), 0);
    chk("rst_key_valid", int'(key_valid), 0);
    run_to(15); chk("sweep_row0_end", int'(K_ROW), 'h1E);
    run_to(16); chk("sweep_row1", int'(K_ROW), 'h1D);
    run_to(32); chk("sweep_row2", int'(K_ROW), 'h1B);
    run_to(48); chk("sweep_row3", int'(K_ROW), 'h17);
    run_to(64); chk("sweep_row4", int'(K_ROW), 'h0F);
    run_to(80); chk("sweep_wrap", int'(K_ROW), 'h1E);
    run_to(90); chk("sweep_no_valid", valid_cnt, 0);

    // Bounce rejection: col 0 low for 20 cycles within the row-1 slot.
    clear_keys();
    do_reset();
    run_to(16); bounce = 1;
    run_to(36); bounce = 0;
    run_to(47); chk("bounce_row_held", int'(K_ROW), 'h1D);
    run_to(48); chk("bounce_resume_row2", int'(K_ROW), 'h1B);
    run_to(120); chk("bounce_no_valid", valid_cnt, 0);

    // Clean press of (2,1): first sample on edge 48, accept on edge 96.
    clear_keys();
    do_reset();
    key_m[2][1] = 1;
    find_valid(at);
    chk("press_latency", at, 96);
    chk("press_code", int'(key_code), 5);
    chk("press_held", int'(key_held), 1);
    chk("press_k_row", int'(K_ROW), 'h1B);

    // Release with one low re-bounce after two high samples.
    key_m[2][1] = 0;
    run_to(128); key_m[2][1] = 1;
    run_to(144); key_m[2][1] = 0;
    chk("held_through_bounce", int'(key_held), 1);
    find_release(at);
    chk("release_latency", at, 208);
    chk("release_held", int'(key_held), 0);
    chk("release_next_row", int'(K_ROW), 'h17);
    chk("release_code_kept", int'(key_code), 5);
    run_to(215);
    chk("press_valid_pulses", valid_cnt, 1);
    chk("release_pulses", rel_pulses, 1);

    // Two columns low on row 4: column 0 wins.
    clear_keys();
    do_reset();
    key_m[4][0] = 1;
    key_m[4][1] = 1;
    find_valid(at);
    chk("two_col_latency", at, 128);
    chk("two_col_code", int'(key_code), 8);
    run_to(200);
    chk("two_col_valid_pulses", valid_cnt, 1);
    chk("two_col_held", int'(key_held), 1);

    // Reset while held.
    @(negedge clk_s);
    rst = 1'b1;
    @(negedge clk_s);
    chk("midrst_k_row", int'(K_ROW), 'h1E);
    chk("midrst_held", int'(key_held), 0);
    chk("midrst_code", int'(key_code), 0);
    chk("midrst_release", int'(key_release), 0);
    rst = 1'b0;
    clear_keys();
    repeat (4) @(negedge clk_s);
    chk("midrst_no_release", rel_pulses, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix-keypad scanner, the device-side end of the K_ROW/K_COL interface of multi_cpu_top.
- Drives one row low at a time and samples the column lines.
- Debounces the press, then reports one key event (code, pulse, held level) to the CPU I/O logic.
- Replaces direct use of raw K_COL in the top level.

Parameters:
- ROWS, 5, number of row lines driven (K_ROW width).
- COLS, 2, number of column lines sampled (K_COL width).
- SCAN_DIV, 16, clock cycles each row stays driven. Columns are sampled on the last cycle of the slot.
- DEBOUNCE, 4, consecutive matching samples needed to accept a press or a release.

Ports:
- clk_s  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- K_COL  in  COLS  column lines, active-low (0 = key closed on the currently driven row), externally pulled up.
- K_ROW  out  ROWS  row drive, active-low one-hot.
- key_code  out  4  row*COLS + col of the last accepted key (0..9 at defaults).
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high from press acceptance until release acceptance.
- key_release  out  1  one-cycle pulse when a release is accepted.

Behaviour:
- Reset, synchronous, high on a rising edge:
  - K_ROW = 11110 (row 0 driven); all counters = 0; state = SCAN.
  - key_code = 0; key_valid = key_held = key_release = 0.
  - Reset asserted in any state aborts immediately; outputs take reset values the next cycle.
- Slot counter: 0..SCAN_DIV-1 free-running. Sample point = count SCAN_DIV-1. K_COL is registered at the sample point only.
- State SCAN:
  - At the sample point, if no column is low, advance the row: r -> r+1, with 4 -> 0 wrap.
  - If any column is low, capture cand = (r, lowest-index low column), set match_cnt = 1 and go to DEBOUNCE_P. The row does not advance.
- State DEBOUNCE_P:
  - Row held. At each sample point, if column cand.col is low, match_cnt++; otherwise return to SCAN and advance to the next row.
  - When match_cnt reaches DEBOUNCE: key_code = cand, key_valid pulses in the following cycle, key_held = 1, go to HELD.
- State HELD:
  - Row held. At each sample point, cand.col high increments rel_cnt; cand.col low clears rel_cnt.
  - When rel_cnt reaches DEBOUNCE: key_release pulses in the following cycle, key_held = 0, go to SCAN and advance to the next row.
  - Other columns are ignored while HELD.
- Latency: key_valid is asserted 1 cycle after the DEBOUNCE-th consecutive low sample, i.e. (DEBOUNCE-1)*SCAN_DIV+1 cycles after the first detecting sample. Release latency is the same.
- Simultaneous columns low on one row: the lowest column index wins; the others are lost.
- key_code holds its value after release until the next accepted press.
- key_valid and key_release never assert in the same cycle.
- Widths: row index $clog2(ROWS), column index $clog2(COLS). key_code is zero-extended to 4 bits.

Decomposition:
- Shared package kbd_pkg holds:
  - state encoding localparams (SCAN, DEBOUNCE_P, HELD);
  - KEY_CODE_W = 4;
  - the key_code formula constant COLS.
- One sub-module, scan_tick: parameterised SCAN_DIV counter with sync reset. It outputs a sample-strobe pulse on count SCAN_DIV-1.
- The FSM, row register and debounce counters stay in keypad_scanner.

Test Plan:
- Idle sweep:
  - Stimulus: rst for 2 cycles, K_COL = 11 constant.
  - Required: K_ROW steps 11110, 11101, 11011, 10111, 01111, each for 16 cycles, then wraps to 11110 at cycle 80. key_valid never pulses.
- Clean press:
  - Stimulus: bench models the matrix with key (row 2, col 1) closed, i.e. K_COL[1] = 0 whenever K_ROW[2] = 0.
  - Required: one key_valid pulse with key_code = 5, exactly 3*16+1 cycles after the first detecting sample. key_held = 1 and K_ROW frozen at 11011.
- Bounce rejection:
  - Stimulus: K_COL[0] low for only 20 cycles during the row-1 slot.
  - Required: no key_valid. Scanning resumes at row 2 (K_ROW = 11011) after the failed debounce sample.
- Two columns:
  - Stimulus: both columns low on row 4.
  - Required: key_code = 8 (column 0 priority); key_valid pulses once.
- Release:
  - Stimulus: from the clean-press case, open the key; include one 16-cycle low re-bounce after 2 high samples.
  - Required: rel_cnt restarts at the bounce. key_release pulses once, after 4 consecutive high samples. key_held = 0; the next row driven is 10111; key_code stays 5.
- Reset mid-HELD:
  - Stimulus: assert rst while key_held = 1.
  - Required: the next cycle has K_ROW = 11110, key_held = 0, key_code = 0, and no key_release pulse.
